updown_counter_param: RTL

//   Parametrised up/down counter: configurable width, range [MIN_VAL..MAX_VAL] and step size.

---
 rtl/updown_counter_param_if.sv | 38 +++
 rtl/updown_counter_param.sv | 109 ++++++++++
 2 files changed

// File: rtl/updown_counter_param_if.sv
// Bus bundle for updown_counter_param: control inputs, count and limit flags.
// The UPDOWN_STICKY_EN macro adds the sticky overflow/underflow signals.
interface updown_counter_param_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_down;
    logic             wrap;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_min;
    logic             tc;
`ifdef UPDOWN_STICKY_EN
    logic             ovf_clr;
    logic             ovf;
    logic             udf;
`endif

    modport master (
        output en, up_down, wrap, load, load_val,
`ifdef UPDOWN_STICKY_EN
        output ovf_clr,
        input  ovf, udf,
`endif
        input  count, at_max, at_min, tc
    );

    modport slave (
        input  en, up_down, wrap, load, load_val,
`ifdef UPDOWN_STICKY_EN
        input  ovf_clr,
        output ovf, udf,
`endif
        output count, at_max, at_min, tc
    );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with per-cycle saturate/wrap, load, limit flags and terminal pulse.
// Optional sticky overflow/underflow flags are compiled in with UPDOWN_STICKY_EN.
module updown_counter_param #(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 15,
    parameter int STEP    = 1,
    parameter int RST_VAL = 0
) (
    input logic                   clk,
    input logic                   reset,
    updown_counter_param_if.slave bus
);
    // Two extra bits: one for the carry of count+STEP, one for the sign of count-STEP.
    typedef logic signed [WIDTH+1:0] ext_t;

    localparam ext_t MIN_E   = ext_t'(MIN_VAL);
    localparam ext_t MAX_E   = ext_t'(MAX_VAL);
    localparam ext_t STEP_E  = ext_t'(STEP);
    localparam ext_t RANGE_E = ext_t'(MAX_VAL - MIN_VAL + 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_q;
    logic             tc_nxt;

    ext_t cnt_e;
    ext_t load_e;
    ext_t sum_e;
    ext_t diff_e;
    ext_t wrap_up_e;
    ext_t wrap_dn_e;

    assign cnt_e     = ext_t'({2'b00, count_q});
    assign load_e    = ext_t'({2'b00, bus.load_val});
    assign sum_e     = cnt_e + STEP_E;
    assign diff_e    = cnt_e - STEP_E;
    assign wrap_up_e = sum_e - RANGE_E;
    assign wrap_dn_e = diff_e + RANGE_E;

    always_comb begin
        count_nxt = count_q;
        tc_nxt    = 1'b0;
        if (bus.load) begin
            if (load_e < MIN_E) begin
                count_nxt = MIN_E[WIDTH-1:0];
            end else if (load_e > MAX_E) begin
                count_nxt = MAX_E[WIDTH-1:0];
            end else begin
                count_nxt = bus.load_val;
            end
        end else if (bus.en) begin
            if (bus.up_down) begin
                if (sum_e > MAX_E) begin
                    tc_nxt    = 1'b1;
                    count_nxt = bus.wrap ? wrap_up_e[WIDTH-1:0] : MAX_E[WIDTH-1:0];
                end else begin
                    count_nxt = sum_e[WIDTH-1:0];
                end
            end else begin
                if (diff_e < MIN_E) begin
                    tc_nxt    = 1'b1;
                    count_nxt = bus.wrap ? wrap_dn_e[WIDTH-1:0] : MIN_E[WIDTH-1:0];
                end else begin
                    count_nxt = diff_e[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= WIDTH'(RST_VAL);
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_nxt;
            tc_q    <= tc_nxt;
        end
    end

    assign bus.count  = count_q;
    assign bus.tc     = tc_q;
    assign bus.at_max = (cnt_e == MAX_E);
    assign bus.at_min = (cnt_e == MIN_E);

`ifdef UPDOWN_STICKY_EN
    // tc_nxt is only raised by an enabled step, so direction alone classifies the event.
    logic ovf_q;
    logic udf_q;
    logic up_hit;
    logic dn_hit;

    assign up_hit = tc_nxt & bus.up_down;
    assign dn_hit = tc_nxt & ~bus.up_down;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= up_hit | (ovf_q & ~bus.ovf_clr);
            udf_q <= dn_hit | (udf_q & ~bus.ovf_clr);
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.udf = udf_q;
`endif
endmodule
